// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard and steering controller for the 16-bit
//               five-stage CPU.
//               - Drives PC / IF-DR enables, IF-DR flush and DR->EX bubble.
//               - Drives the EX operand forwarding selects.
//               - Tracks stall/redirect episodes in a small FSM.
//               - Keeps saturating stall/flush event counters for debug.
// Ports       : clk, reset (sync, active-high)
//               dr_*      : decode-stage operand/jump information
//               ex_*      : execute-stage destination, load and branch result
//               mem_*     : memory-stage destination for forwarding
//               wb_*      : write-back-stage destination for forwarding
//               pc_enable, if_enable, flush_if, bubble_ex : pipeline control
//               fwd_a, fwd_b : 00 regfile, 01 MEM alu_res, 10 WB wd3
//               state, stall_cnt, flush_cnt : debug observation
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       dr_ra1,
    input  logic [3:0]       dr_ra2,
    input  logic             dr_use1,
    input  logic             dr_use2,
    input  logic             dr_jmp,
    input  logic [3:0]       ex_wa3,
    input  logic             ex_we3,
    input  logic             ex_read,
    input  logic             ex_branch_taken,
    input  logic [3:0]       mem_wa3,
    input  logic             mem_we3,
    input  logic [3:0]       wb_wa3,
    input  logic             wb_we3,
    output logic             pc_enable,
    output logic             if_enable,
    output logic             flush_if,
    output logic             bubble_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ex_ra1_q, ex_ra1_d;
    logic [3:0]       ex_ra2_q, ex_ra2_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic w_lu;
    logic w_take_stall;

    // Load-use: the loaded register is needed by DR one cycle too early.
    assign w_lu = ex_read && ex_we3 && (ex_wa3 != 4'd0) &&
                  ((dr_use1 && (dr_ra1 == ex_wa3)) ||
                   (dr_use2 && (dr_ra2 == ex_wa3)));

    // A taken branch makes the DR instruction wrong-path, so its stall is void.
    assign w_take_stall = w_lu && !ex_branch_taken;

    // Pipeline control, zero latency from the current inputs.
    always_comb begin
        pc_enable = 1'b1;
        if_enable = 1'b1;
        flush_if  = 1'b0;
        bubble_ex = 1'b0;
        if (reset || ex_branch_taken) begin
            flush_if  = 1'b1;
            bubble_ex = 1'b1;
        end else if (w_lu) begin
            pc_enable = 1'b0;
            if_enable = 1'b0;
            bubble_ex = 1'b1;
        end else if (dr_jmp) begin
            flush_if  = 1'b1;
        end
    end

    // Next-state decisions for the FSM, EX source copies and counters.
    always_comb begin
        if (ex_branch_taken) begin
            state_d = ST_REDIR;
        end else if (w_lu) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_RUN;
        end

        // A bubble in EX reads nothing, so it must not trigger forwarding.
        ex_ra1_d = bubble_ex ? 4'd0 : dr_ra1;
        ex_ra2_d = bubble_ex ? 4'd0 : dr_ra2;

        stall_cnt_d = stall_cnt_q;
        if (w_take_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if (flush_if && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            ex_ra1_q    <= 4'd0;
            ex_ra2_q    <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_ra1_q    <= ex_ra1_d;
            ex_ra2_q    <= ex_ra2_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Forwarding: the youngest producer (MEM) wins over WB; R0 is never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        if (mem_we3 && (mem_wa3 == ex_ra1_q) && (ex_ra1_q != 4'd0)) begin
            fwd_a = 2'b01;
        end else if (wb_we3 && (wb_wa3 == ex_ra1_q) && (ex_ra1_q != 4'd0)) begin
            fwd_a = 2'b10;
        end

        fwd_b = 2'b00;
        if (mem_we3 && (mem_wa3 == ex_ra2_q) && (ex_ra2_q != 4'd0)) begin
            fwd_b = 2'b01;
        end else if (wb_we3 && (wb_wa3 == ex_ra2_q) && (ex_ra2_q != 4'd0)) begin
            fwd_b = 2'b10;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Each scenario task
//               drives one input vector per cycle, queues the expected
//               outputs, and compares them mid-cycle against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int         CNT_W    = 16;
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;

    typedef struct packed {
        logic [3:0]       ctl;   // {pc_enable, if_enable, flush_if, bubble_ex}
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [1:0]       st;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] dr_ra1, dr_ra2, ex_wa3, mem_wa3, wb_wa3;
    logic dr_use1, dr_use2, dr_jmp, ex_we3, ex_read, ex_branch_taken;
    logic mem_we3, wb_we3;
    logic pc_enable, if_enable, flush_if, bubble_ex;
    logic [1:0] fwd_a, fwd_b, state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   sc_e  = 0;
    int   fc_e  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .dr_ra1          (dr_ra1),
        .dr_ra2          (dr_ra2),
        .dr_use1         (dr_use1),
        .dr_use2         (dr_use2),
        .dr_jmp          (dr_jmp),
        .ex_wa3          (ex_wa3),
        .ex_we3          (ex_we3),
        .ex_read         (ex_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_wa3         (mem_wa3),
        .mem_we3         (mem_we3),
        .pc_enable       (pc_enable),
        .if_enable       (if_enable),
        .flush_if        (flush_if),
        .bubble_ex       (bubble_ex),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .state           (state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .wb_wa3          (wb_wa3),
        .wb_we3          (wb_we3)
    );

    task automatic idle();
        reset = 1'b0; dr_ra1 = 4'd0; dr_ra2 = 4'd0; dr_use1 = 1'b0; dr_use2 = 1'b0;
        dr_jmp = 1'b0; ex_wa3 = 4'd0; ex_we3 = 1'b0; ex_read = 1'b0;
        ex_branch_taken = 1'b0; mem_wa3 = 4'd0; mem_we3 = 1'b0;
        wb_wa3 = 4'd0; wb_we3 = 1'b0;
    endtask

    // Build an expected vector; counters come from the bench's running tallies.
    function automatic vec_t mk(logic [3:0] ctl, logic [1:0] fa, logic [1:0] fb, logic [1:0] st);
        vec_t v;
        v.ctl = ctl; v.fa = fa; v.fb = fb; v.st = st;
        v.sc  = (sc_e > 65535) ? 16'hFFFF : 16'(sc_e);
        v.fc  = (fc_e > 65535) ? 16'hFFFF : 16'(fc_e);
        return v;
    endfunction

    function automatic vec_t obs();
        vec_t v;
        v.ctl = {pc_enable, if_enable, flush_if, bubble_ex};
        v.fa = fwd_a; v.fb = fwd_b; v.st = state; v.sc = stall_cnt; v.fc = flush_cnt;
        return v;
    endfunction

    task automatic test_reset();
        vec_t e, g;
        idle(); reset = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            idle();
            if (s == 0) begin reset = 1'b1; e = mk(4'b1111, 2'b00, 2'b00, ST_RUN); end
            else        begin e = mk(4'b1100, 2'b00, 2'b00, ST_RUN); end
            exp_q.push_back(e);
            @(negedge clk); g = obs(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin n_bad++; $display("FAIL reset step%0d: got %h want %h", s, g, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        vec_t e, g;
        for (int s = 0; s < 3; s++) begin
            idle();
            case (s)
                0: begin ex_read = 1; ex_we3 = 1; ex_wa3 = 4'd3; dr_ra1 = 4'd3; dr_use1 = 1;
                         e = mk(4'b0001, 2'b00, 2'b00, ST_RUN); end
                1: begin dr_ra1 = 4'd3; dr_use1 = 1; mem_wa3 = 4'd3; mem_we3 = 1;
                         e = mk(4'b1100, 2'b00, 2'b00, ST_STALL); end
                default: begin mem_wa3 = 4'd3; mem_we3 = 1;
                         e = mk(4'b1100, 2'b01, 2'b00, ST_RUN); end
            endcase
            exp_q.push_back(e);
            @(negedge clk); g = obs(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin n_bad++; $display("FAIL load_use step%0d: got %h want %h", s, g, e); end
            @(posedge clk); #1;
            if (s == 0) sc_e++;
        end
    endtask

    task automatic test_r0();
        vec_t e, g;
        for (int s = 0; s < 2; s++) begin
            idle();
            if (s == 0) begin
                ex_read = 1; ex_we3 = 1; ex_wa3 = 4'd0; dr_ra1 = 4'd0; dr_use1 = 1;
                dr_ra2 = 4'd0; dr_use2 = 1;
                e = mk(4'b1100, 2'b00, 2'b00, ST_RUN);
            end else begin
                mem_we3 = 1; mem_wa3 = 4'd0; wb_we3 = 1; wb_wa3 = 4'd0;
                e = mk(4'b1100, 2'b00, 2'b00, ST_RUN);
            end
            exp_q.push_back(e);
            @(negedge clk); g = obs(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin n_bad++; $display("FAIL r0 step%0d: got %h want %h", s, g, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fwd_priority();
        vec_t e, g;
        for (int s = 0; s < 4; s++) begin
            idle();
            case (s)
                0: begin dr_ra1 = 4'd5; dr_ra2 = 4'd5; dr_use2 = 1;
                         e = mk(4'b1100, 2'b00, 2'b00, ST_RUN); end
                1: begin dr_ra2 = 4'd5; mem_wa3 = 4'd5; mem_we3 = 1; wb_wa3 = 4'd5; wb_we3 = 1;
                         e = mk(4'b1100, 2'b01, 2'b01, ST_RUN); end
                2: begin mem_wa3 = 4'd5; mem_we3 = 0; wb_wa3 = 4'd5; wb_we3 = 1;
                         e = mk(4'b1100, 2'b00, 2'b10, ST_RUN); end
                default: begin mem_wa3 = 4'd5; mem_we3 = 1; wb_wa3 = 4'd5; wb_we3 = 1;
                         e = mk(4'b1100, 2'b00, 2'b00, ST_RUN); end
            endcase
            exp_q.push_back(e);
            @(negedge clk); g = obs(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin n_bad++; $display("FAIL fwd_priority step%0d: got %h want %h", s, g, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        vec_t e, g;
        for (int s = 0; s < 2; s++) begin
            idle();
            if (s == 0) begin
                ex_branch_taken = 1; dr_jmp = 1;
                ex_read = 1; ex_we3 = 1; ex_wa3 = 4'd3; dr_ra1 = 4'd3; dr_use1 = 1;
                e = mk(4'b1111, 2'b00, 2'b00, ST_RUN);
            end else begin
                mem_wa3 = 4'd3; mem_we3 = 1;
                e = mk(4'b1100, 2'b00, 2'b00, ST_REDIR);
            end
            exp_q.push_back(e);
            @(negedge clk); g = obs(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin n_bad++; $display("FAIL redirect step%0d: got %h want %h", s, g, e); end
            @(posedge clk); #1;
            if (s == 0) fc_e++;
        end
    endtask

    task automatic test_jump();
        vec_t e, g;
        for (int s = 0; s < 2; s++) begin
            idle();
            if (s == 0) begin dr_jmp = 1; dr_ra1 = 4'd4; e = mk(4'b1110, 2'b00, 2'b00, ST_RUN); end
            else        begin mem_wa3 = 4'd4; mem_we3 = 1; e = mk(4'b1100, 2'b01, 2'b00, ST_RUN); end
            exp_q.push_back(e);
            @(negedge clk); g = obs(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin n_bad++; $display("FAIL jump step%0d: got %h want %h", s, g, e); end
            @(posedge clk); #1;
            if (s == 0) fc_e++;
        end
    endtask

    task automatic test_back_to_back();
        vec_t e, g;
        for (int s = 0; s < 3; s++) begin
            idle();
            if (s < 2) begin
                ex_read = 1; ex_we3 = 1; ex_wa3 = 4'd7; dr_ra2 = 4'd7; dr_use2 = 1;
                e = mk(4'b0001, 2'b00, 2'b00, (s == 0) ? ST_RUN : ST_STALL);
            end else begin
                e = mk(4'b1100, 2'b00, 2'b00, ST_STALL);
            end
            exp_q.push_back(e);
            @(negedge clk); g = obs(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin n_bad++; $display("FAIL back_to_back step%0d: got %h want %h", s, g, e); end
            @(posedge clk); #1;
            if (s < 2) sc_e++;
        end
    endtask

    task automatic test_saturation();
        vec_t e, g;
        int   n_jmp;
        n_jmp = (1 << CNT_W) + 3;
        for (int k = 0; k < n_jmp; k++) begin
            idle(); dr_jmp = 1;
            @(posedge clk); #1;
        end
        fc_e += n_jmp;
        for (int s = 0; s < 3; s++) begin
            idle();
            if (s == 1) begin dr_jmp = 1; e = mk(4'b1110, 2'b00, 2'b00, ST_RUN); end
            else        begin e = mk(4'b1100, 2'b00, 2'b00, ST_RUN); end
            exp_q.push_back(e);
            @(negedge clk); g = obs(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin n_bad++; $display("FAIL saturation step%0d: got %h want %h", s, g, e); end
            @(posedge clk); #1;
            if (s == 1) fc_e++;
        end
    endtask

    task automatic test_reset_mid_stall();
        vec_t e, g;
        for (int s = 0; s < 4; s++) begin
            idle();
            if (s < 3) begin
                ex_read = 1; ex_we3 = 1; ex_wa3 = 4'd3; dr_ra1 = 4'd3; dr_use1 = 1;
            end
            case (s)
                0: e = mk(4'b0001, 2'b00, 2'b00, ST_RUN);
                1: begin reset = 1; e = mk(4'b1111, 2'b00, 2'b00, ST_STALL); end
                2: begin reset = 1; e = mk(4'b1111, 2'b00, 2'b00, ST_RUN); end
                default: e = mk(4'b1100, 2'b00, 2'b00, ST_RUN);
            endcase
            exp_q.push_back(e);
            @(negedge clk); g = obs(); e = exp_q.pop_front(); n_vec++;
            if (g !== e) begin n_bad++; $display("FAIL reset_mid_stall step%0d: got %h want %h", s, g, e); end
            @(posedge clk); #1;
            if (s == 0) sc_e++;
            if (s == 1) begin sc_e = 0; fc_e = 0; end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_r0();
        test_fwd_priority();
        test_redirect();
        test_jump();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
